mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one unified single-port memory between the RV32E instruction-fetch port and the load/store port. Sits between the core's fetch/memory stages and the memory macro. Data requests normally win. A streak counter guarantees fetch forward progress. A kill input discards an in-flight fetch response after a taken branch or jump.

## Interface
Parameters:
- `MAX_D_STREAK`, default 3. Number of consecutive data grants allowed while fetch is waiting before fetch is forced to win.

Ports:
- `clk`, in, 1. Single clock; all state updates on the rising edge.
- `rst_n`, in, 1. Synchronous, active-low reset.
- `if_req`, in, 1. Fetch request.
- `if_addr`, in, 32. Fetch byte address.
- `if_gnt`, out, 1. Fetch request accepted this cycle.
- `if_kill`, in, 1. Discard the outstanding fetch response.
- `if_rvalid`, out, 1. Fetch response valid.
- `if_rdata`, out, 32. Fetch response data.
- `d_req`, in, 1. Data request.
- `d_we`, in, 1. 1 = store, 0 = load.
- `d_addr`, in, 32. Data byte address.
- `d_wdata`, in, 32. Store data.
- `d_be`, in, 4. Byte enables.
- `d_gnt`, out, 1. Data request accepted this cycle.
- `d_rvalid`, out, 1. Data response valid (load data or store ack).
- `d_rdata`, out, 32. Load data.
- `mem_req`, out, 1. Memory request.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, out, 1/32/32/4. Memory command fields.
- `mem_gnt`, in, 1. Memory accepts the request.
- `mem_rvalid`, in, 1. Memory response; one response per accepted request, for reads and writes.
- `mem_rdata`, in, 32. Memory read data.

## Operation
- FSM states: IDLE, BUSY.
  - At most one transaction is outstanding.
  - New requests are issued only from IDLE.
- IDLE:
  - `mem_req` = `if_req | d_req`.
  - Selected requester's command is driven onto `mem_*`.
  - When fetch is the selected requester, `mem_we`=0 and `mem_be`=4'hF.
  - `mem_req & mem_gnt` → latch `owner` (IF/D), go to BUSY.
- BUSY:
  - `mem_req`=0.
  - On `mem_rvalid`: route the response to `owner`, go to IDLE.
- Arbitration, evaluated in IDLE:
  - Only one requester active → that requester wins.
  - Both active → D wins, unless `streak == MAX_D_STREAK`, in which case IF wins.
- Streak counter, width `$clog2(MAX_D_STREAK+1)`:
  - On a D grant with `if_req`=1: increment, saturating at `MAX_D_STREAK`.
  - On a D grant with `if_req`=0: clear.
  - On an IF grant: clear.
- Grants:
  - `if_gnt = mem_req & mem_gnt & (sel==IF)`.
  - `d_gnt` is defined the same way for D.
  - Both are combinational; they are never high in the same cycle.
- Requester rule:
  - Request and its command fields are held stable until the corresponding gnt.
  - The losing requester simply keeps waiting.
- Responses:
  - `if_rvalid = mem_rvalid & BUSY & owner==IF & !killed`.
  - `d_rvalid = mem_rvalid & BUSY & owner==D`.
  - `if_rdata` and `d_rdata` both carry `mem_rdata` unconditionally.
- Kill:
  - `if_kill`=1 while BUSY with owner IF sets `killed`.
  - `if_kill`=1 in the cycle of `mem_rvalid` also suppresses `if_rvalid`.
  - Killed response: memory handshake completes normally and the FSM returns to IDLE; `killed` clears.
  - `if_kill` in IDLE has no effect.
  - `if_kill` when owner is D has no effect.
- `mem_rvalid` in IDLE is ignored; no output, no state change.
- Reset (`rst_n`=0 at a rising edge):
  - state→IDLE, owner→IF, `killed`→0, streak→0.
- While `rst_n`=0:
  - All outputs are forced low combinationally.
  - This applies to `mem_req`, `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `mem_we`, `mem_be`, and all data/address buses (driven 0).
- Reset mid-transaction: the in-flight response is dropped because the FSM is in IDLE.

## Timing
- Request to grant: 0 cycles, combinational, when `mem_gnt`=1 in the same cycle.
- Grant to response: memory latency L≥1 cycles.
  - Response appears combinationally, in the same cycle as `mem_rvalid`.
- Throughput: one transaction per L+1 cycles minimum (grant cycle + L; the response cycle returns to IDLE).
- Next request can be granted the cycle after `mem_rvalid`.
- Combinational paths:
  - `mem_gnt` → `if_gnt`/`d_gnt`.
  - `mem_rvalid` → `*_rvalid`.
  - `if_kill` → `if_rvalid`.

## Test plan
- **Reset values:** hold `rst_n`=0 for 2 cycles with `if_req`=`d_req`=1 → all outputs 0. Release; first cycle → `mem_req`=1, `d_gnt`=1.
- **Fetch only:** `if_req`=1, `if_addr`=0x100, memory L=1, `mem_rdata`=0x00000013 → `if_gnt` in cycle 0; `if_rvalid`=1 with 0x00000013 in cycle 1; `mem_we`=0, `mem_be`=F.
- **Contention/starvation:** `MAX_D_STREAK`=3, both requesting continuously, L=1 → grant order D,D,D,IF,D,D,D,IF; each grant is 2 cycles apart.
- **Store ack:** `d_req`=1, `d_we`=1, `d_addr`=0x2004, `d_wdata`=0xDEADBEEF, `d_be`=4'b0011 → `mem_*` fields match; `d_rvalid`=1 one cycle after grant; `if_rvalid` stays 0.
- **Kill:** fetch granted, L=3, `if_kill` pulsed in cycle 1 → no `if_rvalid` in cycle 3; FSM back in IDLE; a `d_req` in cycle 4 is granted.
- **Reset mid-flight / stray response:** assert reset in BUSY, then `mem_rvalid`=1 after release → no `*_rvalid`; the next request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-side signals
// of the shared single-port memory arbiter.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_kill;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, if_kill,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch vs load/store arbiter for one unified memory.
// Data wins by default; a streak counter forces fetch progress.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int SW =
    (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic { IDLE, BUSY } state_e;
  typedef enum logic { OWN_IF, OWN_D } owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          killed_q, killed_d;
  logic [SW-1:0] streak_q, streak_d;

  logic idle;
  logic busy;
  logic req_any;
  logic sel_if;
  logic fire;

  // Arbitration: fetch wins alone or once data has hogged the port.
  always_comb begin
    idle    = (state_q == IDLE);
    busy    = (state_q == BUSY);
    req_any = bus.if_req | bus.d_req;
    sel_if  = bus.if_req &
              (~bus.d_req | (streak_q == STREAK_MAX));
    fire    = idle & req_any & bus.mem_gnt;
  end

  // Outputs: command mux, grants, response routing; zero in reset.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rdata   = '0;
    if (rst_n) begin
      bus.mem_req   = idle & req_any;
      bus.mem_we    = sel_if ? 1'b0 : bus.d_we;
      bus.mem_addr  = sel_if ? bus.if_addr : bus.d_addr;
      bus.mem_wdata = sel_if ? '0 : bus.d_wdata;
      bus.mem_be    = sel_if ? 4'hF : bus.d_be;
      bus.if_gnt    = fire & sel_if;
      bus.d_gnt     = fire & ~sel_if;
      bus.if_rvalid = bus.mem_rvalid & busy &
                      (owner_q == OWN_IF) &
                      ~killed_q & ~bus.if_kill;
      bus.d_rvalid  = bus.mem_rvalid & busy &
                      (owner_q == OWN_D);
      bus.if_rdata  = bus.mem_rdata;
      bus.d_rdata   = bus.mem_rdata;
    end
  end

  // Next state: issue from IDLE, wait for the one response in BUSY.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    killed_d = killed_q;
    streak_d = streak_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d  = BUSY;
          killed_d = 1'b0;
          if (sel_if) begin
            owner_d  = OWN_IF;
            streak_d = '0;
          end else begin
            owner_d = OWN_D;
            if (!bus.if_req) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + SW'(1);
            end
          end
        end
      end
      BUSY: begin
        if (bus.if_kill && owner_q == OWN_IF) begin
          killed_d = 1'b1;
        end
        if (bus.mem_rvalid) begin
          state_d  = IDLE;
          killed_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      killed_q <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      killed_q <= killed_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of the arbiter and memory.
module tb_mem_arbiter;

  localparam int MAXS = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  bit m_busy, m_own_d, m_killed;
  int m_streak;

  // memory model
  logic [31:0] mem [256];
  logic [31:0] rd_q;
  int lat_left = 0;
  int lat_fix = 1;
  int gnt_pct = 100;
  int stray_pct = 0;

  // random driver
  bit rnd = 0;
  bit if_pend = 0, d_pend = 0;

  // per-cycle expectations
  bit e_mreq, e_sel_if, e_fire, e_if_gnt, e_d_gnt;
  bit e_if_rv, e_d_rv;
  logic got_if_gnt, got_d_gnt;

  string glog;
  int gc[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic settle();
    bit stray;
    if (rnd) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1;
        bus.if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1;
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = $urandom() & 32'hFFFF_FFFC;
        bus.d_wdata = $urandom();
        bus.d_be = 4'($urandom_range(1, 15));
      end
      bus.if_req = if_pend;
      bus.d_req = d_pend;
      bus.if_kill = ($urandom_range(0, 4) == 0);
    end
    bus.mem_gnt = ($urandom_range(0, 99) < gnt_pct);
    stray = (lat_left == 0) &&
            ($urandom_range(0, 99) < stray_pct);
    bus.mem_rvalid = (lat_left == 1) || stray;
    bus.mem_rdata = (lat_left == 1) ? rd_q : $urandom();
    #4;
    if (!rst_n) begin
      e_fire = 0; e_if_gnt = 0; e_d_gnt = 0;
      chk("rst_ctl", {bus.mem_req, bus.mem_we, bus.mem_be,
                      bus.if_gnt, bus.d_gnt,
                      bus.if_rvalid, bus.d_rvalid}, 0);
      chk("rst_bus", bus.mem_addr | bus.mem_wdata |
                     bus.if_rdata | bus.d_rdata, 0);
    end else begin
      e_mreq = !m_busy && (bus.if_req || bus.d_req);
      e_sel_if = bus.if_req &&
                 (!bus.d_req || m_streak == MAXS);
      e_fire = e_mreq && bus.mem_gnt;
      e_if_gnt = e_fire && e_sel_if;
      e_d_gnt = e_fire && !e_sel_if;
      e_if_rv = m_busy && bus.mem_rvalid && !m_own_d &&
                !m_killed && !bus.if_kill;
      e_d_rv = m_busy && bus.mem_rvalid && m_own_d;
      chk("mem_req", bus.mem_req, e_mreq);
      chk("if_gnt", bus.if_gnt, e_if_gnt);
      chk("d_gnt", bus.d_gnt, e_d_gnt);
      chk("if_rvalid", bus.if_rvalid, e_if_rv);
      chk("d_rvalid", bus.d_rvalid, e_d_rv);
      chk("if_rdata", bus.if_rdata, bus.mem_rdata);
      chk("d_rdata", bus.d_rdata, bus.mem_rdata);
      if (e_mreq) begin
        chk("mem_we", bus.mem_we, e_sel_if ? 0 : bus.d_we);
        chk("mem_addr", bus.mem_addr,
            e_sel_if ? bus.if_addr : bus.d_addr);
        chk("mem_be", bus.mem_be,
            e_sel_if ? 4'hF : bus.d_be);
        if (!e_sel_if)
          chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
      end
    end
    got_if_gnt = bus.if_gnt;
    got_d_gnt = bus.d_gnt;
  endtask

  task automatic tick();
    logic [7:0] ix;
    @(posedge clk);
    if (lat_left > 0) lat_left--;
    if (!rst_n) begin
      m_busy = 0; m_own_d = 0; m_killed = 0; m_streak = 0;
    end else if (!m_busy) begin
      if (e_fire) begin
        m_busy = 1;
        m_own_d = !e_sel_if;
        m_killed = 0;
        if (e_sel_if) m_streak = 0;
        else if (bus.if_req)
          m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        else m_streak = 0;
      end
    end else begin
      if (bus.if_kill && !m_own_d) m_killed = 1;
      if (bus.mem_rvalid) begin
        m_busy = 0;
        m_killed = 0;
      end
    end
    if (e_fire) begin
      lat_left = (lat_fix != 0) ? lat_fix
                                : $urandom_range(1, 3);
      ix = e_sel_if ? bus.if_addr[9:2] : bus.d_addr[9:2];
      rd_q = mem[ix];
      if (!e_sel_if && bus.d_we)
        for (int b = 0; b < 4; b++)
          if (bus.d_be[b])
            mem[ix][8*b +: 8] = bus.d_wdata[8*b +: 8];
      if (e_if_gnt) if_pend = 0;
      if (e_d_gnt) d_pend = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    bus.if_req = 0; bus.d_req = 0; bus.if_kill = 0;
    settle();
    tick();
    lat_left = 0;
    rst_n = 1;
  endtask

  task automatic drain(input int n);
    bus.if_req = 0; bus.d_req = 0; bus.if_kill = 0;
    for (int i = 0; i < n; i++) begin
      settle();
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i * 32'h0101_0101;
    mem[8'h40] = 32'h0000_0013;
    rst_n = 0;
    bus.if_req = 1; bus.if_addr = 32'h100; bus.if_kill = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
    bus.d_wdata = 0; bus.d_be = 4'hF;
    bus.mem_gnt = 1; bus.mem_rvalid = 0; bus.mem_rdata = 0;

    // reset held two cycles with both requesting
    settle(); tick();
    settle(); tick();
    rst_n = 1;
    settle();
    chk("rel_mem_req", bus.mem_req, 1);
    chk("rel_d_gnt", bus.d_gnt, 1);
    tick();
    drain(2);

    // fetch only, L=1
    do_reset();
    bus.if_req = 1; bus.if_addr = 32'h100;
    settle();
    chk("fo_if_gnt", bus.if_gnt, 1);
    chk("fo_we", bus.mem_we, 0);
    chk("fo_be", bus.mem_be, 4'hF);
    tick();
    bus.if_req = 0;
    settle();
    chk("fo_rvalid", bus.if_rvalid, 1);
    chk("fo_rdata", bus.if_rdata, 32'h13);
    tick();

    // contention: D,D,D,IF repeating, two cycles apart
    do_reset();
    bus.if_req = 1; bus.if_addr = 32'h200;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    glog = "";
    for (int i = 0; i < 16; i++) begin
      settle();
      if (got_d_gnt) begin glog = {glog, "D"}; gc.push_back(cyc); end
      if (got_if_gnt) begin glog = {glog, "I"}; gc.push_back(cyc); end
      tick();
    end
    chk("cont_order", (glog == "DDDIDDDI"), 1);
    chk("cont_count", gc.size(), 8);
    for (int k = 1; k < gc.size(); k++)
      chk("cont_gap", gc[k] - gc[k-1], 2);
    drain(2);

    // store ack
    do_reset();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
    settle();
    chk("st_gnt", bus.d_gnt, 1);
    chk("st_we", bus.mem_we, 1);
    chk("st_addr", bus.mem_addr, 32'h2004);
    chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("st_be", bus.mem_be, 4'b0011);
    tick();
    bus.d_req = 0;
    settle();
    chk("st_ack", bus.d_rvalid, 1);
    chk("st_if_rv", bus.if_rvalid, 0);
    tick();

    // kill of an in-flight fetch, L=3
    do_reset();
    lat_fix = 3;
    bus.if_req = 1; bus.if_addr = 32'h100;
    settle();
    chk("kl_if_gnt", bus.if_gnt, 1);
    tick();
    bus.if_req = 0; bus.if_kill = 1;
    settle(); tick();
    bus.if_kill = 0;
    settle(); tick();
    settle();
    chk("kl_no_rv", bus.if_rvalid, 0);
    tick();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
    settle();
    chk("kl_d_gnt", bus.d_gnt, 1);
    tick();
    drain(4);

    // reset while busy, then a stray response
    do_reset();
    bus.if_req = 1; bus.if_addr = 32'h104;
    settle(); tick();
    bus.if_req = 0;
    settle(); tick();
    rst_n = 0;
    settle(); tick();
    rst_n = 1;
    settle();
    chk("sr_mem_rv", bus.mem_rvalid, 1);
    chk("sr_if_rv", bus.if_rvalid, 0);
    chk("sr_d_rv", bus.d_rvalid, 0);
    tick();
    bus.d_req = 1; bus.d_addr = 32'h44;
    settle();
    chk("sr_d_gnt", bus.d_gnt, 1);
    tick();
    drain(4);
    lat_fix = 1;

    // random traffic
    do_reset();
    rnd = 1; lat_fix = 0; gnt_pct = 75; stray_pct = 10;
    if_pend = 0; d_pend = 0;
    for (int i = 0; i < 3000; i++) begin
      settle();
      tick();
    end
    rnd = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
